// File: rtl/obs_split_24bit.sv
// Operand splitter for the OBS GF(2) multiplier: splits A/B into even/odd bit
// subwords plus their XOR sums, buffered in a 2-entry valid/ready FIFO.
module obs_split_24bit #(
    parameter int N     = 24,
    parameter int CNT_W = 16,
    localparam int H    = N / 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     A_in,
    input  logic [N-1:0]     B_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [H-1:0]     Ae_out,
    output logic [H-1:0]     Ao_out,
    output logic [H-1:0]     Be_out,
    output logic [H-1:0]     Bo_out,
    output logic [H-1:0]     As_out,
    output logic [H-1:0]     Bs_out,
    output logic [CNT_W-1:0] acc_count
);

    localparam int EW = 6 * H;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]       r_occ;
    logic [1:0]       w_occ_nxt;
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic             r_in_ready;
    logic [EW-1:0]    r_mem [2];
    logic [CNT_W-1:0] r_acc_count;

    logic [H-1:0]     w_ae;
    logic [H-1:0]     w_ao;
    logic [H-1:0]     w_be;
    logic [H-1:0]     w_bo;
    logic [EW-1:0]    w_entry;
    logic [EW-1:0]    w_head;
    logic             w_push;
    logic             w_pop;

    always_comb begin
        w_ae = '0;
        w_ao = '0;
        w_be = '0;
        w_bo = '0;
        for (int i = 0; i < H; i++) begin
            w_ae[i] = A_in[2*i];
            w_ao[i] = A_in[2*i+1];
            w_be[i] = B_in[2*i];
            w_bo[i] = B_in[2*i+1];
        end
    end

    // Entry layout, MSB first: As, Bs, Ae, Ao, Be, Bo
    assign w_entry = {w_ae ^ w_ao, w_be ^ w_bo, w_ae, w_ao, w_be, w_bo};

    assign w_push = in_valid && r_in_ready;
    assign w_pop  = (r_occ != ST_EMPTY) && out_ready;

    always_comb begin
        w_occ_nxt = r_occ;
        case (r_occ)
            ST_EMPTY: w_occ_nxt = w_push ? ST_ONE : ST_EMPTY;
            ST_ONE: begin
                if (w_push && !w_pop)
                    w_occ_nxt = ST_FULL;
                else if (w_pop && !w_push)
                    w_occ_nxt = ST_EMPTY;
                else
                    w_occ_nxt = ST_ONE;
            end
            ST_FULL:  w_occ_nxt = w_pop ? ST_ONE : ST_FULL;
            default:  w_occ_nxt = ST_EMPTY;
        endcase
    end

    // in_ready comes from the next-state decode so it is a pure register output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_occ       <= ST_EMPTY;
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_in_ready  <= 1'b1;
            r_acc_count <= '0;
            r_mem[0]    <= '0;
            r_mem[1]    <= '0;
        end else begin
            r_occ      <= w_occ_nxt;
            r_in_ready <= (w_occ_nxt != ST_FULL);
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_entry;
                r_wr_ptr        <= ~r_wr_ptr;
                r_acc_count     <= r_acc_count + 1'b1;
            end
            if (w_pop)
                r_rd_ptr <= ~r_rd_ptr;
        end
    end

    assign w_head    = r_mem[r_rd_ptr];
    assign As_out    = w_head[6*H-1 -: H];
    assign Bs_out    = w_head[5*H-1 -: H];
    assign Ae_out    = w_head[4*H-1 -: H];
    assign Ao_out    = w_head[3*H-1 -: H];
    assign Be_out    = w_head[2*H-1 -: H];
    assign Bo_out    = w_head[H-1 -: H];
    assign out_valid = (r_occ != ST_EMPTY);
    assign in_ready  = r_in_ready;
    assign acc_count = r_acc_count;

endmodule
